// File: rtl/aes_key_expand_ctrl.sv
// -----------------------------------------------------------------------------
// aes_key_expand_ctrl
//
// Word-serial AES-128 key-expansion sequencer. Loads a 128-bit cipher key,
// presents round key 0, then builds each following round key one 32-bit word
// per cycle, in place, using a shared external combinational S-box for
// SubWord(RotWord(w3)) and an internal Rcon table indexed by the round counter.
// Round keys 0..NUM_ROUNDS are handed to the cipher over a valid/ready
// handshake.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   start     in   begin expansion (ignored unless IDLE)
//   key_in    in   cipher key, bits 127:96 are w0, sampled on accepted start
//   sbox_in   out  RotWord(w3) toward the shared S-box
//   sbox_out  in   SubWord(sbox_in), same cycle
//   rk_valid  out  round key available
//   rk_ready  in   consumer accepts the round key
//   rk_round  out  index of the presented round key (0..10)
//   rk_data   out  round key {w0,w1,w2,w3}
//   busy      out  high in every state except IDLE
//   done      out  one-cycle pulse after the last round key is accepted
//   abort     in   (only with AES_KEY_EXPAND_ABORT_EN) return to IDLE
//
// Optional feature macro: AES_KEY_EXPAND_ABORT_EN adds the abort input.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// EMIT  | round key presented, waiting for rk_ready
// GEN   | building next round key, word idx 0..3, one per cycle
// DONE  | one-cycle done pulse, then IDLE
// -----------------------------------------------------------------------------

module aes_rcon (
    input  logic [3:0] round,
    output logic [7:0] rcon
);
    always_comb begin
        case (round)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end
endmodule

module aes_key_expand_ctrl #(
    parameter int WORD       = 32,
    parameter int SENTENCE   = 128,
    parameter int NUM_ROUNDS = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [SENTENCE-1:0] key_in,
    output logic [WORD-1:0]     sbox_in,
    input  logic [WORD-1:0]     sbox_out,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [3:0]          rk_round,
    output logic [SENTENCE-1:0] rk_data,
    output logic                busy,
    output logic                done
`ifdef AES_KEY_EXPAND_ABORT_EN
    ,
    input  logic                abort
`endif
);

    typedef enum logic [1:0] {IDLE, EMIT, GEN, DONE} state_t;

    state_t          state, state_nxt;
    logic [WORD-1:0] w0, w1, w2, w3;
    logic [WORD-1:0] w0_nxt, w1_nxt, w2_nxt, w3_nxt;
    logic [3:0]      round_nxt;
    logic [1:0]      idx, idx_nxt;
    logic [3:0]      rcon_round;
    logic [7:0]      rcon_out;
    logic            abort_req;

`ifdef AES_KEY_EXPAND_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Rcon index is parked at 0 while idle so the table never sees a stale round.
    assign rcon_round = busy ? rk_round : 4'd0;

    aes_rcon u_rcon (
        .round (rcon_round),
        .rcon  (rcon_out)
    );

    assign sbox_in = {w3[WORD-9:0], w3[WORD-1 -: 8]};
    assign rk_data = {w0, w1, w2, w3};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            w0       <= '0;
            w1       <= '0;
            w2       <= '0;
            w3       <= '0;
            rk_round <= '0;
            idx      <= '0;
        end else begin
            state    <= state_nxt;
            w0       <= w0_nxt;
            w1       <= w1_nxt;
            w2       <= w2_nxt;
            w3       <= w3_nxt;
            rk_round <= round_nxt;
            idx      <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        w0_nxt    = w0;
        w1_nxt    = w1;
        w2_nxt    = w2;
        w3_nxt    = w3;
        round_nxt = rk_round;
        idx_nxt   = idx;
        rk_valid  = (state == EMIT);
        busy      = (state != IDLE);
        done      = (state == DONE);

        case (state)
            IDLE: begin
                if (start) begin
                    w0_nxt    = key_in[SENTENCE-1 -: WORD];
                    w1_nxt    = key_in[SENTENCE-WORD-1 -: WORD];
                    w2_nxt    = key_in[SENTENCE-2*WORD-1 -: WORD];
                    w3_nxt    = key_in[SENTENCE-3*WORD-1 -: WORD];
                    round_nxt = 4'd0;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                // abort wins over a same-cycle handshake
                if (abort_req) begin
                    state_nxt = IDLE;
                end else if (rk_ready) begin
                    if (rk_round == 4'(NUM_ROUNDS)) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = 2'd0;
                        state_nxt = GEN;
                    end
                end
            end
            GEN: begin
                if (abort_req) begin
                    state_nxt = IDLE;
                end else begin
                    idx_nxt = idx + 2'd1;
                    case (idx)
                        2'd0: w0_nxt = w0 ^ sbox_out ^ {rcon_out, {(WORD-8){1'b0}}};
                        2'd1: w1_nxt = w1 ^ w0;
                        2'd2: w2_nxt = w2 ^ w1;
                        default: begin
                            w3_nxt    = w3 ^ w2;
                            round_nxt = rk_round + 4'd1;
                            state_nxt = EMIT;
                        end
                    endcase
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
module tb_aes_key_expand_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic [31:0]  sbox_in;
    logic [31:0]  sbox_out;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_round;
    logic [127:0] rk_data;
    logic         busy;
    logic         done;
`ifdef AES_KEY_EXPAND_ABORT_EN
    logic         abort;
`endif

    always #5 clk = ~clk;

    aes_key_expand_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
        .sbox_in  (sbox_in),
        .sbox_out (sbox_out),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_round (rk_round),
        .rk_data  (rk_data),
        .busy     (busy),
        .done     (done)
`ifdef AES_KEY_EXPAND_ABORT_EN
        ,
        .abort    (abort)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0]   round;
        logic [127:0] data;
    } exp_t;
    exp_t sbq[$];

    logic [127:0] got_rk [0:10];

    typedef struct {
        logic [127:0] key;
        logic [127:0] rk1;
        logic [127:0] rk3;
        logic [127:0] rk10;
        bit           has_rk3;
        int           stall_round;
        int           stall_len;
        bit           gen_start;
    } vec_t;

    // ---------------- reference S-box and key schedule ----------------
    function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b  = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(logic [7:0] x, int n);
        logic [7:0] r;
        r = (x << n) | (x >> (8 - n));
        return r;
    endfunction

    function automatic logic [7:0] sbox_b(logic [7:0] a);
        logic [7:0] inv = 8'h00;
        for (int i = 1; i < 256; i++)
            if (gf_mul(a, 8'(i)) == 8'h01) inv = 8'(i);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(logic [31:0] x);
        return {sbox_b(x[31:24]), sbox_b(x[23:16]), sbox_b(x[15:8]), sbox_b(x[7:0])};
    endfunction

    function automatic logic [127:0] model_rk(logic [127:0] key, int r);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    assign sbox_out = subword(sbox_in);

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Caller is at a negedge with the DUT idle. Drives start in cycle 0.
    task automatic run_exp(input logic [127:0] key, input int stall_round,
                           input int stall_len, input bit gen_start);
        int   stalled    = 0;
        int   nacc       = 0;
        bit   prev_valid = 1'b0;
        bit   seen_done  = 1'b0;
        int   off;
        exp_t e;
        for (int r = 0; r <= 10; r++) sbq.push_back('{4'(r), model_rk(key, r)});
        start    = 1'b1;
        key_in   = key;
        rk_ready = 1'b1;
        cyc      = 0;
        while (cyc < 150 && !seen_done) begin
            tick();
            start  = 1'b0;
            key_in = key;
            rk_ready = 1'b1;
            if (gen_start && cyc == 3) begin
                chk("busy_in_gen", 128'(busy), 128'd1);
                chk("valid_in_gen", 128'(rk_valid), 128'd0);
                start  = 1'b1;
                key_in = '1;
            end
            if (rk_valid) begin
                if (sbq.size() == 0) begin
                    chk("sbq_underflow", 128'(rk_valid), 128'd0);
                end else begin
                    e   = sbq[0];
                    off = (int'(e.round) > stall_round) ? stall_len : 0;
                    if (!prev_valid)
                        chk("valid_cycle", 128'(cyc), 128'(1 + 5*int'(e.round) + off));
                    chk("rk_round", 128'(rk_round), 128'(e.round));
                    chk("rk_data", rk_data, e.data);
                    if (int'(e.round) == stall_round && stalled < stall_len) begin
                        rk_ready = 1'b0;
                        stalled++;
                    end else begin
                        got_rk[e.round] = rk_data;
                        void'(sbq.pop_front());
                        nacc++;
                    end
                end
            end
            if (done) begin
                seen_done = 1'b1;
                chk("done_cycle", 128'(cyc), 128'(52 + stall_len));
                chk("keys_accepted", 128'(nacc), 128'd11);
                chk("busy_in_done", 128'(busy), 128'd1);
            end
            prev_valid = rk_valid;
        end
        if (!seen_done) chk("done_timeout", 128'd0, 128'd1);
        tick();
        chk("done_one_cycle", 128'(done), 128'd0);
        chk("idle_after_done", 128'(busy), 128'd0);
        sbq.delete();
    endtask

    vec_t vecs [0:3];

    initial begin
        vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'ha0fafe1788542cb123a339392a6c7605,
                    128'h3d80477d4716fe3e1e237e446d7a883b,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1, -1, 0, 1'b0};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'ha0fafe1788542cb123a339392a6c7605,
                    128'h3d80477d4716fe3e1e237e446d7a883b,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1, 3, 7, 1'b0};
        vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'ha0fafe1788542cb123a339392a6c7605,
                    128'h3d80477d4716fe3e1e237e446d7a883b,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1, -1, 0, 1'b1};
        vecs[3] = '{128'h0,
                    128'h62636363626363636263636362636363,
                    128'h0,
                    128'hb4ef5bcb3e92e21123e951cf6f8f188e, 1'b0, -1, 0, 1'b0};

        rst_n    = 1'b0;
        start    = 1'b0;
        key_in   = '0;
        rk_ready = 1'b0;
`ifdef AES_KEY_EXPAND_ABORT_EN
        abort    = 1'b0;
`endif
        tick();
        tick();
        chk("rst_valid", 128'(rk_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_round", 128'(rk_round), 128'd0);
        chk("rst_data", rk_data, 128'd0);
        chk("rst_sbox_in", 128'(sbox_in), 128'd0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 4; v++) begin
            run_exp(vecs[v].key, vecs[v].stall_round, vecs[v].stall_len, vecs[v].gen_start);
            chk("tbl_rk0", got_rk[0], vecs[v].key);
            chk("tbl_rk1", got_rk[1], vecs[v].rk1);
            if (vecs[v].has_rk3) chk("tbl_rk3", got_rk[3], vecs[v].rk3);
            chk("tbl_rk10", got_rk[10], vecs[v].rk10);
            tick();
        end

        // Reset in the middle of generating round key 6.
        start  = 1'b1;
        key_in = vecs[0].key;
        rk_ready = 1'b1;
        cyc    = 0;
        tick();
        start  = 1'b0;
        while (cyc < 28) tick();
        chk("pre_rst_valid", 128'(rk_valid), 128'd0);
        chk("pre_rst_busy", 128'(busy), 128'd1);
        chk("pre_rst_round", 128'(rk_round), 128'd5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_valid", 128'(rk_valid), 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_done", 128'(done), 128'd0);
        chk("mid_rst_round", 128'(rk_round), 128'd0);
        chk("mid_rst_data", rk_data, 128'd0);
        chk("mid_rst_sbox_in", 128'(sbox_in), 128'd0);
        tick();
        run_exp(vecs[0].key, -1, 0, 1'b0);
        chk("post_rst_rk0", got_rk[0], vecs[0].key);
        tick();

`ifdef AES_KEY_EXPAND_ABORT_EN
        // Abort while round key 4 is presented, with rk_ready also high.
        start  = 1'b1;
        key_in = vecs[0].key;
        rk_ready = 1'b1;
        cyc    = 0;
        tick();
        start  = 1'b0;
        while (cyc < 21) tick();
        chk("abort_pre_valid", 128'(rk_valid), 128'd1);
        chk("abort_pre_round", 128'(rk_round), 128'd4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", 128'(rk_valid), 128'd0);
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_done", 128'(done), 128'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_done", 128'(done), 128'd0);
            chk("abort_stays_idle", 128'(busy), 128'd0);
        end
        run_exp(vecs[0].key, -1, 0, 1'b0);
        chk("abort_restart_rk10", got_rk[10], vecs[0].rk10);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_key_expand_ctrl.md
Name: aes_key_expand_ctrl

Overview:
- Word-serial AES-128 key-expansion sequencer.
- Loads a 128-bit cipher key and steps the round index 0..9 into an internal Rcon instance.
- Drives RotWord of the last word to a shared external S-box port and builds each round key one 32-bit word per cycle.
- Delivers round keys 0..10 to the cipher datapath over a valid/ready handshake.

Parameters:
- WORD, 32, word width in bits; fixed at 32 for AES.
- SENTENCE, 128, key and round-key width in bits.
- NUM_ROUNDS, 10, number of generated round keys after round key 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin expansion; ignored unless state is IDLE.
- key_in  in  128  cipher key; sampled on the accepted start cycle; bits 127:96 are w0.
- sbox_in  out  32  RotWord(w3) = {w3[23:0], w3[31:24]}; driven to the shared combinational S-box.
- sbox_out  in  32  SubWord result; valid in the same cycle as sbox_in.
- rk_valid  out  1  round key available.
- rk_ready  in  1  consumer accepts the round key.
- rk_round  out  4  index of the presented round key, 0..10.
- rk_data  out  128  round key {w0,w1,w2,w3}.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after round key 10 is accepted.

Behaviour:
- Reset (rst_n=0 at a clock edge, from any state):
  - State goes to IDLE.
  - w0..w3, rk_round, word index and sbox_in are cleared to 0.
  - rk_valid, busy and done go to 0.
  - Reset mid-expansion discards all progress.
- IDLE + start:
  - Load w0..w3 from key_in and set rk_round=0.
  - Next state EMIT. rk_valid rises on the cycle after start.
- EMIT:
  - rk_valid=1.
  - rk_data and rk_round are held stable until rk_valid and rk_ready are both high.
  - On acceptance with rk_round=NUM_ROUNDS: go to DONE.
  - On acceptance with rk_round below NUM_ROUNDS: go to GEN with idx=0.
- GEN (4 cycles, idx 0..3):
  - rk_valid=0. Words are updated in place.
  - idx0: w0 <= w0 ^ sbox_out ^ rcon_out. The Rcon round input is rk_round, which equals r-1 when generating round key r, so Rcon index 0..9 maps to values 01..36.
  - idx1: w1 <= w1 ^ w0. w0 is already updated.
  - idx2: w2 <= w2 ^ w1.
  - idx3: w3 <= w3 ^ w2. At the same edge rk_round increments and the next state is EMIT.
  - sbox_in is driven continuously from the current w3. The bench's S-box is sampled only at idx0.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - busy stays 1 during DONE.
- Rcon round input:
  - Driven only from rk_round while busy. Forced to 0 in IDLE so the Rcon output never goes to z.
- Timing with rk_ready held at 1:
  - Round key k is valid at cycle 1+5k after start.
  - Round key 10 is valid at cycle 51; done pulses at cycle 52.
- Backpressure:
  - Stalling in EMIT for any number of cycles changes nothing.
  - rk_ready while rk_valid=0 is ignored.
- start while busy: ignored; no reload.
- Widths: all XORs are 32-bit. rk_round never exceeds 10 and never wraps.

Optional Feature:
- Macro: AES_KEY_EXPAND_ABORT_EN.
- With the macro defined:
  - Adds input port abort (1 bit).
  - abort=1 in any non-IDLE state forces IDLE on the next edge.
  - rk_valid and busy drop that edge; done is not pulsed.
  - w registers keep their values.
  - In the same cycle, abort has priority over the rk handshake.
  - abort in IDLE has no effect.
- Without the macro: the port is absent and expansion always runs to completion or reset.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1, bench S-box model:
  - rk_round0 = the key at cycle 1.
  - rk_round1 = a0fafe1788542cb123a339392a6c7605 at cycle 6.
  - rk_round10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at cycle 51.
  - done at cycle 52.
- Same key, rk_ready low for 7 cycles on round 3 (key 3d80477d4716fe3e1e237e446d7a883b):
  - rk_data and rk_round stay stable while stalled.
  - Final keys are unchanged; done is delayed by 7 cycles.
- start pulsed during GEN with key_in=all ones:
  - No reload; the round sequence matches the first scenario.
- rst_n=0 asserted in GEN of round 5:
  - Next cycle all outputs are 0 and the state is IDLE.
  - A new start reproduces round key 0 correctly.
- All-zero key:
  - rk_round1 = 62636363626363636263636362636363.
  - rk_round10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- With AES_KEY_EXPAND_ABORT_EN: abort in EMIT of round 4:
  - rk_valid=0 next cycle, busy=0, no done pulse.
  - A restart produces the full sequence.
